// File: rtl/ay_psg_sequencer_if.sv
// Bundle of the BK parallel-port, AY bus and status signals of ay_psg_sequencer.
//   slave  : the sequencer (consumes BK strobe/qualifiers, drives AY bus/status)
//   master : the BK/AY environment side
// Signals: strobe/iwrbt/dout/isel/din  BK port inputs (asynchronous)
//          ay_din                      AY DA read-back
//          ay_dout/ay_doe              AY DA data and drive enable
//          ay_bdir/ay_bc1              per-chip bus control
//          rd_data/rd_valid            last read value and update pulse
//          busy/ovr/err/ovr_clr        status flags and sticky-overrun clear
interface ay_psg_sequencer_if #(
  parameter int NCHIP = 2
);
  logic             strobe;
  logic             iwrbt;
  logic             dout;
  logic             isel;
  logic [7:0]       din;
  logic [7:0]       ay_din;
  logic [7:0]       ay_dout;
  logic             ay_doe;
  logic [NCHIP-1:0] ay_bdir;
  logic [NCHIP-1:0] ay_bc1;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             ovr;
  logic             err;
  logic             ovr_clr;

  modport slave (
    input  strobe, iwrbt, dout, isel, din, ay_din, ovr_clr,
    output ay_dout, ay_doe, ay_bdir, ay_bc1, rd_data, rd_valid, busy, ovr, err
  );

  modport master (
    output strobe, iwrbt, dout, isel, din, ay_din, ovr_clr,
    input  ay_dout, ay_doe, ay_bdir, ay_bc1, rd_data, rd_valid, busy, ovr, err
  );
endinterface

// File: rtl/ay_psg_sequencer.sv
// Converts BK parallel-port strobes into AY-3-8910 bus cycles (LADDR/WRPSG/RDPSG)
// for up to four chips.
// Ports: clk, rst (synchronous, active-high) and bus (ay_psg_sequencer_if.slave).
// Parameters: NCHIP chips served, MODE command decoding (0 Novo, 1 Stas1,
// 2 Stas2), SETUP_CYC data setup clocks, PULSE_CYC bus-control pulse clocks.
module ay_psg_sequencer #(
  parameter int NCHIP     = 2,
  parameter int MODE      = 0,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  ay_psg_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
  typedef enum logic [1:0] {C_LADDR, C_WRPSG, C_RDPSG} cmd_t;

  // {strobe, iwrbt, dout, isel, din}
  logic [11:0] sync1, sync2;
  logic        strobe_q;
  logic [2:0]  warm;

  logic        s_strobe, s_iwrbt, s_dout, s_isel;
  logic [7:0]  s_din;
  logic        cmd_edge;
  logic        idx_ok;
  cmd_t        dec;

  state_t           state;
  cmd_t             cmd;
  logic [3:0]       cnt;
  logic [1:0]       sel;
  logic [1:0]       tgt;
  logic [NCHIP-1:0] tgt_mask;
  logic [1:0]       code;

  assign {s_strobe, s_iwrbt, s_dout, s_isel, s_din} = sync2;

  // The edge detector is masked until strobe_q holds a genuine post-reset
  // sample, so a strobe held high across reset release is not a command.
  assign cmd_edge = s_strobe & ~strobe_q & warm[2];

  // Validity uses both index bits even for NCHIP<=2, so din[5]=1 is rejected
  // there; once accepted, din[5:4] equals the effective chip number.
  assign idx_ok = ({1'b0, s_din[5:4]} < 3'(NCHIP));

  assign tgt_mask = NCHIP'(1) << tgt;
  assign bus.busy = (state != S_IDLE);

  always_comb begin
    dec = C_RDPSG;
    if (s_dout) begin
      case (MODE)
        0:       dec = s_iwrbt ? C_LADDR : C_WRPSG;
        1:       dec = s_iwrbt ? C_WRPSG : C_LADDR;
        default: dec = s_isel  ? C_WRPSG : C_LADDR;
      endcase
    end
  end

  always_comb begin
    code = 2'b00;
    case (cmd)
      C_LADDR: code = 2'b11;
      C_WRPSG: code = 2'b10;
      C_RDPSG: code = 2'b01;
      default: code = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= '0;
      sync2        <= '0;
      strobe_q     <= 1'b0;
      warm         <= '0;
      state        <= S_IDLE;
      cmd          <= C_LADDR;
      cnt          <= '0;
      sel          <= '0;
      tgt          <= '0;
      bus.ay_dout  <= '0;
      bus.ay_doe   <= 1'b0;
      bus.ay_bdir  <= '0;
      bus.ay_bc1   <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.ovr      <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      sync1    <= {bus.strobe, bus.iwrbt, bus.dout, bus.isel, bus.din};
      sync2    <= sync1;
      strobe_q <= s_strobe;
      warm     <= {warm[1:0], 1'b1};

      bus.err      <= 1'b0;
      bus.rd_valid <= 1'b0;

      if (cmd_edge && (state != S_IDLE)) begin
        bus.ovr <= 1'b1;
      end else if (bus.ovr_clr) begin
        bus.ovr <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_edge) begin
            if ((dec == C_LADDR) && !idx_ok) begin
              bus.err <= 1'b1;
            end else begin
              cmd   <= dec;
              state <= S_SETUP;
              cnt   <= 4'(SETUP_CYC - 1);
              case (dec)
                C_LADDR: begin
                  sel         <= s_din[5:4];
                  tgt         <= s_din[5:4];
                  bus.ay_dout <= {4'b0000, s_din[3:0]};
                  bus.ay_doe  <= 1'b1;
                end
                C_WRPSG: begin
                  tgt         <= sel;
                  bus.ay_dout <= s_din;
                  bus.ay_doe  <= 1'b1;
                end
                default: begin
                  tgt         <= sel;
                  bus.ay_dout <= '0;
                  bus.ay_doe  <= 1'b0;
                end
              endcase
            end
          end
        end
        S_SETUP: begin
          if (cnt == 4'd0) begin
            state       <= S_PULSE;
            cnt         <= 4'(PULSE_CYC - 1);
            bus.ay_bdir <= code[1] ? tgt_mask : '0;
            bus.ay_bc1  <= code[0] ? tgt_mask : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_PULSE: begin
          if (cnt == 4'd0) begin
            state       <= S_HOLD;
            bus.ay_bdir <= '0;
            bus.ay_bc1  <= '0;
            if (cmd == C_RDPSG) begin
              bus.rd_data  <= bus.ay_din;
              bus.rd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          state       <= S_IDLE;
          bus.ay_doe  <= 1'b0;
          bus.ay_dout <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ay_psg_sequencer.sv
module tb_ay_psg_sequencer;

  localparam int K_TXN = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    int         dut;
    logic [1:0] bdir;
    logic [1:0] bc1;
    logic [7:0] dout;
    bit         chk_dout;
    int         setup_n;
    int         pulse_n;
    int         busy_n;
    int         doe_n;
    int         lat;
    int         steady;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  ev_t exp_q[$];

  int strobe_cyc [3];
  int m_busy  [3];
  int m_doe   [3];
  int m_setup [3];
  int m_pulse [3];
  int m_lat   [3];
  int m_steady[3];
  logic [1:0] m_bdir [3];
  logic [1:0] m_bc1  [3];
  logic [7:0] m_dout [3];

  ay_psg_sequencer_if #(.NCHIP(2)) b0 ();
  ay_psg_sequencer_if #(.NCHIP(2)) b1 ();
  ay_psg_sequencer_if #(.NCHIP(2)) b2 ();

  ay_psg_sequencer #(.NCHIP(2), .MODE(0), .SETUP_CYC(2), .PULSE_CYC(3))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  ay_psg_sequencer #(.NCHIP(2), .MODE(1), .SETUP_CYC(2), .PULSE_CYC(3))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  ay_psg_sequencer #(.NCHIP(2), .MODE(2), .SETUP_CYC(2), .PULSE_CYC(3))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_ev(input ev_t obs);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL unexpected_event actual=kind%0d/dut%0d required=none (cycle %0d)",
               obs.kind, obs.dut, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", obs.kind, e.kind);
      chk("ev_dut", obs.dut, e.dut);
      if (e.kind == K_TXN) begin
        chk("txn_bdir", int'(obs.bdir), int'(e.bdir));
        chk("txn_bc1", int'(obs.bc1), int'(e.bc1));
        if (e.chk_dout) chk("txn_dout", int'(obs.dout), int'(e.dout));
        chk("txn_setup_clks", obs.setup_n, e.setup_n);
        chk("txn_pulse_clks", obs.pulse_n, e.pulse_n);
        chk("txn_busy_clks", obs.busy_n, e.busy_n);
        chk("txn_doe_clks", obs.doe_n, e.doe_n);
        chk("txn_latency", obs.lat, e.lat);
        chk("txn_pulse_steady", obs.steady, 1);
      end else if (e.kind == K_RD) begin
        chk("rd_data", int'(obs.data), int'(e.data));
      end
    end
  endtask

  task automatic mon_step(input int d, input logic [1:0] bdir, input logic [1:0] bc1,
                          input logic [7:0] dout, input logic doe, input logic busy,
                          input logic rdv, input logic [7:0] rdd, input logic err);
    ev_t o;
    o = '{kind: K_ERR, dut: d, bdir: 2'b00, bc1: 2'b00, dout: 8'h00, chk_dout: 1'b0,
          setup_n: 0, pulse_n: 0, busy_n: 0, doe_n: 0, lat: 0, steady: 1, data: 8'h00};
    if (err) compare_ev(o);
    if (rdv) begin
      o.kind = K_RD;
      o.data = rdd;
      compare_ev(o);
    end
    if (busy) begin
      m_busy[d] = m_busy[d] + 1;
      if (doe) m_doe[d] = m_doe[d] + 1;
      if ((bdir | bc1) != 2'b00) begin
        if (m_pulse[d] == 0) begin
          m_bdir[d] = bdir;
          m_bc1[d]  = bc1;
          m_dout[d] = dout;
          m_lat[d]  = cyc - strobe_cyc[d];
          m_steady[d] = 1;
        end else if (bdir != m_bdir[d] || bc1 != m_bc1[d] || dout != m_dout[d]) begin
          m_steady[d] = 0;
        end
        m_pulse[d] = m_pulse[d] + 1;
      end else if (m_pulse[d] == 0) begin
        m_setup[d] = m_setup[d] + 1;
      end
    end else begin
      if ((bdir | bc1) != 2'b00) chk("bus_code_while_idle", int'({bdir, bc1}), 0);
      if (m_busy[d] > 0) begin
        o.kind = K_TXN;
        o.bdir = m_bdir[d];
        o.bc1 = m_bc1[d];
        o.dout = m_dout[d];
        o.setup_n = m_setup[d];
        o.pulse_n = m_pulse[d];
        o.busy_n = m_busy[d];
        o.doe_n = m_doe[d];
        o.lat = m_lat[d];
        o.steady = m_steady[d];
        compare_ev(o);
      end
      m_busy[d] = 0; m_doe[d] = 0; m_setup[d] = 0; m_pulse[d] = 0;
      m_bdir[d] = 2'b00; m_bc1[d] = 2'b00; m_dout[d] = 8'h00; m_lat[d] = 0; m_steady[d] = 1;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, b0.ay_bdir, b0.ay_bc1, b0.ay_dout, b0.ay_doe, b0.busy, b0.rd_valid, b0.rd_data, b0.err);
    mon_step(1, b1.ay_bdir, b1.ay_bc1, b1.ay_dout, b1.ay_doe, b1.busy, b1.rd_valid, b1.rd_data, b1.err);
    mon_step(2, b2.ay_bdir, b2.ay_bc1, b2.ay_dout, b2.ay_doe, b2.busy, b2.rd_valid, b2.rd_data, b2.err);
  end

  task automatic push_txn(input int d, input logic [1:0] bdir, input logic [1:0] bc1,
                          input logic [7:0] dout, input bit chkd, input int pulse_n,
                          input int busy_n, input int doe_n);
    ev_t e;
    e = '{kind: K_TXN, dut: d, bdir: bdir, bc1: bc1, dout: dout, chk_dout: chkd,
          setup_n: 2, pulse_n: pulse_n, busy_n: busy_n, doe_n: doe_n, lat: 5,
          steady: 1, data: 8'h00};
    exp_q.push_back(e);
  endtask

  task automatic push_simple(input int kind, input int d, input logic [7:0] data);
    ev_t e;
    e = '{kind: kind, dut: d, bdir: 2'b00, bc1: 2'b00, dout: 8'h00, chk_dout: 1'b0,
          setup_n: 0, pulse_n: 0, busy_n: 0, doe_n: 0, lat: 0, steady: 1, data: data};
    exp_q.push_back(e);
  endtask

  task automatic set_q(input int d, input logic stb, input logic dv, input logic iw,
                       input logic is, input logic [7:0] dn);
    case (d)
      0: begin b0.strobe = stb; b0.dout = dv; b0.iwrbt = iw; b0.isel = is; b0.din = dn; end
      1: begin b1.strobe = stb; b1.dout = dv; b1.iwrbt = iw; b1.isel = is; b1.din = dn; end
      default: begin b2.strobe = stb; b2.dout = dv; b2.iwrbt = iw; b2.isel = is; b2.din = dn; end
    endcase
  endtask

  // Strobe high for two clocks with stable qualifiers; returns two negedges later.
  task automatic issue(input int d, input logic dv, input logic iw, input logic is,
                       input logic [7:0] dn);
    @(negedge clk);
    set_q(d, 1'b1, dv, iw, is, dn);
    strobe_cyc[d] = cyc;
    repeat (2) @(negedge clk);
    set_q(d, 1'b0, dv, iw, is, dn);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bdir"}, int'(b0.ay_bdir), 0);
    chk({tag, "_bc1"}, int'(b0.ay_bc1), 0);
    chk({tag, "_doe"}, int'(b0.ay_doe), 0);
    chk({tag, "_dout"}, int'(b0.ay_dout), 0);
    chk({tag, "_busy"}, int'(b0.busy), 0);
    chk({tag, "_rd_valid"}, int'(b0.rd_valid), 0);
    chk({tag, "_err"}, int'(b0.err), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    cyc = 0; checks = 0; failures = 0;
    for (int i = 0; i < 3; i++) begin
      strobe_cyc[i] = 0; m_busy[i] = 0; m_doe[i] = 0; m_setup[i] = 0; m_pulse[i] = 0;
      m_lat[i] = 0; m_steady[i] = 1; m_bdir[i] = 2'b00; m_bc1[i] = 2'b00; m_dout[i] = 8'h00;
      set_q(i, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    end
    b0.ay_din = 8'hCD; b1.ay_din = 8'hCD; b2.ay_din = 8'hCD;
    b0.ovr_clr = 1'b0; b1.ovr_clr = 1'b0; b2.ovr_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_rd_data", int'(b0.rd_data), 0);
    chk("reset_ovr", int'(b0.ovr), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // LADDR chip1 reg 0xA
    push_txn(0, 2'b10, 2'b10, 8'h0A, 1'b1, 3, 6, 6);
    issue(0, 1'b1, 1'b1, 1'b1, 8'h1A); settle();
    // WRPSG 0x5C to chip1
    push_txn(0, 2'b10, 2'b00, 8'h5C, 1'b1, 3, 6, 6);
    issue(0, 1'b1, 1'b0, 1'b1, 8'h5C); settle();
    // RDPSG from chip1, AY returns 0xCD
    push_simple(K_RD, 0, 8'hCD);
    push_txn(0, 2'b00, 2'b10, 8'h00, 1'b0, 3, 6, 0);
    issue(0, 1'b0, 1'b1, 1'b1, 8'h00); settle();
    chk("rd_data_held", int'(b0.rd_data), 8'hCD);
    // LADDR chip2 with NCHIP=2: error only, chip1 stays selected
    push_simple(K_ERR, 0, 8'h00);
    issue(0, 1'b1, 1'b1, 1'b1, 8'h2F); settle();
    push_txn(0, 2'b10, 2'b00, 8'h33, 1'b1, 3, 6, 6);
    issue(0, 1'b1, 1'b0, 1'b1, 8'h33); settle();

    // Second strobe during PULSE: dropped, ovr set
    push_txn(0, 2'b10, 2'b00, 8'h77, 1'b1, 3, 6, 6);
    issue(0, 1'b1, 1'b0, 1'b1, 8'h77);
    repeat (2) @(negedge clk);
    set_q(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77);
    repeat (2) @(negedge clk);
    set_q(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    settle();
    chk("ovr_set", int'(b0.ovr), 1);
    b0.ovr_clr = 1'b1;
    @(negedge clk);
    b0.ovr_clr = 1'b0;
    chk("ovr_cleared", int'(b0.ovr), 0);

    // Reset during PULSE aborts immediately
    push_txn(0, 2'b10, 2'b00, 8'h11, 1'b1, 1, 3, 3);
    issue(0, 1'b1, 1'b0, 1'b1, 8'h11);
    repeat (3) @(negedge clk);
    chk("pulse_before_abort", int'(b0.ay_bdir), 2);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    // Chip selection returned to 0 by reset
    push_txn(0, 2'b01, 2'b00, 8'h22, 1'b1, 3, 6, 6);
    issue(0, 1'b1, 1'b0, 1'b1, 8'h22); settle();

    // Strobe held high through reset release: no command
    @(negedge clk);
    set_q(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_strobe_busy", int'(b0.busy), 0);
    set_q(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    repeat (4) @(negedge clk);

    // LADDR chip0 reg 5
    push_txn(0, 2'b01, 2'b01, 8'h05, 1'b1, 3, 6, 6);
    issue(0, 1'b1, 1'b1, 1'b1, 8'h05); settle();

    // MODE 1: iwrbt meaning swapped
    push_txn(1, 2'b10, 2'b10, 8'h0A, 1'b1, 3, 6, 6);
    issue(1, 1'b1, 1'b0, 1'b1, 8'h1A); settle();
    push_txn(1, 2'b10, 2'b00, 8'h5C, 1'b1, 3, 6, 6);
    issue(1, 1'b1, 1'b1, 1'b1, 8'h5C); settle();

    // MODE 2: isel selects LADDR/WRPSG, iwrbt ignored
    push_txn(2, 2'b10, 2'b10, 8'h0A, 1'b1, 3, 6, 6);
    issue(2, 1'b1, 1'b0, 1'b0, 8'h1A); settle();
    push_txn(2, 2'b10, 2'b00, 8'h5C, 1'b1, 3, 6, 6);
    issue(2, 1'b1, 1'b1, 1'b1, 8'h5C); settle();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
